fetch_unit: RTL

Front end of the fetch stage; sits directly upstream of the fetch/decode pipeline registers. Holds the program counter, issues one instruction-cache read at a time, waits for `cache_op_done_in`, and presents the fetched word with its PC (`rm0`) and a valid strobe to the fetch registers. Handles downstream stalls and branch redirects, including a redirect that arrives while a cache read is outstanding.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- front end of the fetch stage.
//
// Holds the program counter and issues one instruction-cache read at a
// time. Each read is held until the cache pulses cache_op_done_in. The
// fetched word and its PC are then presented to the fetch/decode registers
// together with a valid strobe. The unit handles downstream stalls and
// branch redirects, including a redirect that arrives while a read is
// still outstanding. In that case the read is drained and its data is
// discarded.
//
// Parameters
//   WORD_WIDTH    instruction/address width
//   BOOT_ADDRESS  PC after reset (word aligned)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_in            downstream cannot take a new instruction
//   branch_taken_in     one-cycle redirect request
//   branch_target_in    redirect PC
//   cache_req_out       read request, held until cache_op_done_in
//   cache_addr_out      read address, stable while cache_req_out=1
//   cache_data_in       instruction word, valid with cache_op_done_in
//   cache_op_done_in    one-cycle completion pulse
//   rm0_out             PC of instruction_out
//   instruction_out     fetched instruction
//   valid_out           instruction_out/rm0_out hold a live instruction
//   fault_out           sticky misaligned-target fault
//
// Build option
//   FETCH_ALIGN_CHECK_EN  when defined, a redirect target with bits [1:0]
//                         not zero raises fault_out and parks the unit in
//                         FAULT until reset. When undefined, fault_out is 0
//                         and target bits [1:0] are forced to zero.
module fetch_unit #(
  parameter int unsigned               WORD_WIDTH   = 32,
  parameter logic [WORD_WIDTH-1:0]     BOOT_ADDRESS = WORD_WIDTH'(32'h0000_1000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_in,
  input  logic                  branch_taken_in,
  input  logic [WORD_WIDTH-1:0] branch_target_in,
  output logic                  cache_req_out,
  output logic [WORD_WIDTH-1:0] cache_addr_out,
  input  logic [WORD_WIDTH-1:0] cache_data_in,
  input  logic                  cache_op_done_in,
  output logic [WORD_WIDTH-1:0] rm0_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  valid_out,
  output logic                  fault_out
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, FAULT} state_t;
`else
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
`endif

  state_t                state, state_d, resume;
  logic [WORD_WIDTH-1:0] pc, pc_d, target;
  logic                  done, load, valid_d;

  // A completion only counts against a request that is actually raised.
  assign done = cache_op_done_in & cache_req_out;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_set;

  assign target    = branch_target_in;
  assign fault_set = branch_taken_in & (|branch_target_in[1:0]) & (state != FAULT);
  assign fault_out = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
  end
`else
  assign target    = {branch_target_in[WORD_WIDTH-1:2], 2'b00};
  assign fault_out = 1'b0;
`endif

  // Where to go once no read is pending. A fault raised now, or earlier
  // during a drain, parks the unit instead of resuming the fetch.
  always_comb begin
    resume = FETCH;
`ifdef FETCH_ALIGN_CHECK_EN
    if (fault_q || fault_set) resume = FAULT;
`endif
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    valid_d = valid_out;
    load    = 1'b0;
    unique case (state)
      FETCH: begin
        if (branch_taken_in) begin
          pc_d    = target;
          valid_d = 1'b0;
          // A read that is still in flight must complete before the
          // target can be requested. Its data is thrown away.
          if (cache_req_out && !done) state_d = DRAIN;
          else                        state_d = resume;
        end else if (done) begin
          load    = 1'b1;
          valid_d = 1'b1;
          pc_d    = pc + WORD_WIDTH'(4);
          if (stall_in) state_d = HOLD;
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken_in) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = resume;
        end else if (!stall_in) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        valid_d = 1'b0;
        if (branch_taken_in) pc_d = target;
        if (done)            state_d = resume;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      FAULT: begin
        valid_d = 1'b0;
      end
`endif
      default: begin
        state_d = FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  // The request is registered from the next state. It therefore first
  // rises on the edge after reset release, and the new address is in place
  // on the edge where the previous read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= FETCH;
      pc              <= BOOT_ADDRESS;
      cache_req_out   <= 1'b0;
      cache_addr_out  <= '0;
      rm0_out         <= '0;
      instruction_out <= '0;
      valid_out       <= 1'b0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      valid_out     <= valid_d;
      cache_req_out <= (state_d == FETCH) || (state_d == DRAIN);
      if (state_d == FETCH) cache_addr_out <= pc_d;
      if (load) begin
        instruction_out <= cache_data_in;
        rm0_out         <= pc;
      end
    end
  end

endmodule
